// File: rtl/hack_cpu.sv
// Single-cycle Hack CPU core: A/D/PC registers, 16-bit ALU, jump unit.
// ROM and data memory are external and read combinationally.
module hack_cpu (
   input  logic        clk,
   input  logic        rstn,
   input  logic [15:0] inM,
   input  logic [15:0] instruction,
   output logic [15:0] outM,
   output logic        writeM,
   output logic [15:0] addressMR,
   output logic [15:0] addressMW,
   output logic [15:0] pc
);

   logic [15:0] a_q;
   logic [15:0] d_q;
   logic [15:0] pc_q;

   logic        is_c;
   logic        sel_m;
   logic        zx, nx, zy, ny, fn, no;
   logic        d1, d2, d3;
   logic        j1, j2, j3;

   logic [15:0] x0, x1, y0, y1;
   logic [15:0] alu_raw;
   logic [15:0] alu_out;
   logic        zr, ng;
   logic        jmp;

   assign is_c  = instruction[15];
   assign sel_m = instruction[12];
   assign zx    = instruction[11];
   assign nx    = instruction[10];
   assign zy    = instruction[9];
   assign ny    = instruction[8];
   assign fn    = instruction[7];
   assign no    = instruction[6];
   assign d1    = instruction[5];
   assign d2    = instruction[4];
   assign d3    = instruction[3];
   assign j1    = instruction[2];
   assign j2    = instruction[1];
   assign j3    = instruction[0];

   always_comb begin
      x0      = zx ? 16'h0000 : d_q;
      x1      = nx ? ~x0 : x0;
      y0      = zy ? 16'h0000 : (sel_m ? inM : a_q);
      y1      = ny ? ~y0 : y0;
      alu_raw = fn ? (x1 + y1) : (x1 & y1);
      alu_out = no ? ~alu_raw : alu_raw;
   end

   assign zr  = (alu_out == 16'h0000);
   assign ng  = alu_out[15];
   assign jmp = is_c & ((j1 & ng) | (j2 & zr) | (j3 & ~ng & ~zr));

   assign outM      = alu_out;
   assign writeM    = is_c & d3 & rstn;
   assign addressMR = a_q;
   assign addressMW = a_q;
   assign pc        = pc_q;

   // Jump target is the pre-update A, even when d1 rewrites A this cycle
   always_ff @(posedge clk) begin
      if (!rstn) begin
         a_q  <= 16'h0000;
         d_q  <= 16'h0000;
         pc_q <= 16'h0000;
      end else begin
         if (!is_c)
            a_q <= instruction;
         else if (d1)
            a_q <= alu_out;
         if (is_c && d2)
            d_q <= alu_out;
         pc_q <= jmp ? a_q : pc_q + 16'h0001;
      end
   end

endmodule

// File: tb/tb_hack_cpu.sv
// Directed bench for hack_cpu: reset, loads, ALU ops, M operand,
// jumps, A-update hazard, PC wrap and mid-program reset.
module tb_hack_cpu;

   logic        clk;
   logic        rstn;
   logic [15:0] inM;
   logic [15:0] instruction;
   logic [15:0] outM;
   logic        writeM;
   logic [15:0] addressMR;
   logic [15:0] addressMW;
   logic [15:0] pc;

   int n_checks;
   int n_fails;

   hack_cpu dut (
      .clk         (clk),
      .rstn        (rstn),
      .inM         (inM),
      .instruction (instruction),
      .outM        (outM),
      .writeM      (writeM),
      .addressMR   (addressMR),
      .addressMW   (addressMW),
      .pc          (pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic set(input logic [15:0] ins, input logic [15:0] m);
      @(negedge clk);
      instruction = ins;
      inM         = m;
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs,
                      input logic [15:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      n_checks    = 0;
      n_fails     = 0;
      rstn        = 1'b0;
      instruction = 16'hFFFF;
      inM         = 16'h0000;

      // reset held with M=-1;JMP style instruction
      set(16'hFFFF, 16'h0000);
      chk("rst_pc0", pc, 16'h0000);
      chk("rst_wm0", {15'd0, writeM}, 16'h0001 & 16'h0000);
      set(16'hFFFF, 16'h0000);
      chk("rst_pc1", pc, 16'h0000);
      chk("rst_wm1", {15'd0, writeM}, 16'h0000);
      chk("rst_addr", addressMW, 16'h0000);
      chk("rst_outm", outM, 16'h0001);

      // @8192 ; D=1 ; M=D
      set(16'h2000, 16'h0000);
      rstn = 1'b1;
      #1;
      chk("pc_0", pc, 16'h0000);
      chk("a_wm", {15'd0, writeM}, 16'h0000);
      set(16'hEFD0, 16'h0000);
      chk("pc_1", pc, 16'h0001);
      chk("d1_wm", {15'd0, writeM}, 16'h0000);
      chk("d1_out", outM, 16'h0001);
      set(16'hE308, 16'h0000);
      chk("pc_2", pc, 16'h0002);
      chk("md_addrw", addressMW, 16'h2000);
      chk("md_addrr", addressMR, 16'h2000);
      chk("md_out", outM, 16'h0001);
      chk("md_wm", {15'd0, writeM}, 16'h0001);

      // D=5, A=3
      set(16'h0005, 16'h0000);
      chk("after_w_wm", {15'd0, writeM}, 16'h0000);
      set(16'hEC10, 16'h0000);
      set(16'h0003, 16'h0000);
      set(16'hE080, 16'h0000);
      chk("alu_dpa", outM, 16'h0008);
      chk("alu_wm", {15'd0, writeM}, 16'h0000);
      set(16'hE4C0, 16'h0000);
      chk("alu_dma", outM, 16'h0002);
      set(16'hE1C0, 16'h0000);
      chk("alu_amd", outM, 16'hFFFE);
      set(16'hE000, 16'h0000);
      chk("alu_and", outM, 16'h0001);
      set(16'hE540, 16'h0000);
      chk("alu_or", outM, 16'h0007);
      set(16'hE340, 16'h0000);
      chk("alu_notd", outM, 16'hFFFA);
      set(16'hE3C0, 16'h0000);
      chk("alu_negd", outM, 16'hFFFB);
      set(16'hE7C0, 16'h0000);
      chk("alu_dp1", outM, 16'h0006);
      chk("pc_13", pc, 16'h000D);

      // D=M+1 with inM=0x10, then M=D
      set(16'hFDD0, 16'h0010);
      chk("m_plus1", outM, 16'h0011);
      set(16'hE308, 16'h0000);
      chk("m_wr_out", outM, 16'h0011);
      chk("m_wr_wm", {15'd0, writeM}, 16'h0001);
      chk("m_wr_addr", addressMW, 16'h0003);

      // jumps
      set(16'h0040, 16'h0000);
      set(16'hEA90, 16'h0000);
      set(16'hE302, 16'h0000);
      chk("jeq_pc", pc, 16'h0012);
      set(16'h0040, 16'h0000);
      chk("jeq_taken", pc, 16'h0040);
      set(16'hEFD0, 16'h0000);
      set(16'hE302, 16'h0000);
      chk("jeq_nt_pc", pc, 16'h0042);
      set(16'h7FFF, 16'h0000);
      chk("jeq_not", pc, 16'h0043);
      set(16'hEDD0, 16'h0000);
      chk("d_8000", outM, 16'h8000);
      set(16'h0040, 16'h0000);
      set(16'hE304, 16'h0000);
      set(16'h0100, 16'h0000);
      chk("jlt_taken", pc, 16'h0040);
      set(16'hEA87, 16'h0000);
      chk("jmp_pc", pc, 16'h0041);

      // AM=M+1;JMP hazard
      set(16'h0020, 16'h0000);
      chk("jmp_taken", pc, 16'h0100);
      set(16'hFDEF, 16'h0041);
      chk("hz_addr", addressMW, 16'h0020);
      chk("hz_wm", {15'd0, writeM}, 16'h0001);
      chk("hz_out", outM, 16'h0042);
      set(16'hEC00, 16'h0000);
      chk("hz_pc", pc, 16'h0020);
      chk("hz_a", outM, 16'h0042);

      // PC wrap
      set(16'hEEA0, 16'h0000);
      set(16'hEA87, 16'h0000);
      set(16'h0005, 16'h0000);
      chk("pc_ffff", pc, 16'hFFFF);
      set(16'h0000, 16'h0000);
      chk("pc_wrap", pc, 16'h0000);

      // mid-program reset with M=D pending
      set(16'h0007, 16'h0000);
      set(16'hE308, 16'h0000);
      rstn = 1'b0;
      #1;
      chk("mr_wm", {15'd0, writeM}, 16'h0000);
      chk("mr_outd", outM, 16'h8000);
      set(16'hE300, 16'h0000);
      rstn = 1'b1;
      #1;
      chk("mr_pc", pc, 16'h0000);
      chk("mr_d", outM, 16'h0000);
      chk("mr_a", addressMW, 16'h0000);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fails);
      $finish;
   end

endmodule
